// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter: valid/ready upstream, stallable serial side,
// variable frame length (1..WIDTH bits), selectable bit order, zero-bubble frames.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned LW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             par_valid_i,
    input  logic [WIDTH-1:0] par_data_i,
    input  logic [LW-1:0]    par_len_i,
    output logic             par_ready_o,
    input  logic             ser_ready_i,
    output logic             ser_o,
    output logic             ser_valid_o,
    output logic             ser_last_o,
    output logic             empty_o
);

    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    len_eff;
    logic             load;
    logic             consume;
    logic             out_bit;

    // Out-of-range or zero length means a full word.
    always_comb begin
        len_eff = par_len_i;
        if (par_len_i == '0 || par_len_i > WIDTH_L) begin
            len_eff = WIDTH_L;
        end
    end

    assign ser_valid_o = (cnt_q != '0);
    assign ser_last_o  = (cnt_q == ONE_L);
    assign empty_o     = (cnt_q == '0);
    assign par_ready_o = empty_o || (ser_valid_o && ser_ready_i && ser_last_o);

    assign out_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign ser_o   = ser_valid_o & out_bit;

    assign load    = par_valid_i & par_ready_o;
    assign consume = ser_valid_o & ser_ready_i;

    // A load on the last-bit edge takes priority over the final consume.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            cnt_d = len_eff;
            if (MSB_FIRST) begin
                shift_d = par_data_i << (WIDTH_L - len_eff);
            end else begin
                shift_d = par_data_i;
            end
        end else if (consume) begin
            cnt_d = cnt_q - ONE_L;
            if (MSB_FIRST) begin
                shift_d = shift_q << 1;
            end else begin
                shift_d = shift_q >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: an LSB-first and an MSB-first instance share inputs; frame
// vectors run back-to-back from a table, plus stall and reset sequences.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       par_valid;
    logic [7:0] par_data;
    logic [3:0] par_len;
    logic       ser_ready;

    logic ready_l, ser_l, valid_l, last_l, empty_l;
    logic ready_m, ser_m, valid_m, last_m, empty_m;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset),
        .par_valid_i(par_valid), .par_data_i(par_data), .par_len_i(par_len),
        .par_ready_o(ready_l), .ser_ready_i(ser_ready),
        .ser_o(ser_l), .ser_valid_o(valid_l), .ser_last_o(last_l), .empty_o(empty_l)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset),
        .par_valid_i(par_valid), .par_data_i(par_data), .par_len_i(par_len),
        .par_ready_o(ready_m), .ser_ready_i(ser_ready),
        .ser_o(ser_m), .ser_valid_o(valid_m), .ser_last_o(last_m), .empty_o(empty_m)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Idle/reset state of both instances.
    task automatic check_idle(input string tag);
        check({tag, " valid_l"}, 8'(valid_l), 8'd0);
        check({tag, " valid_m"}, 8'(valid_m), 8'd0);
        check({tag, " ser_l"},   8'(ser_l),   8'd0);
        check({tag, " ser_m"},   8'(ser_m),   8'd0);
        check({tag, " last_l"},  8'(last_l),  8'd0);
        check({tag, " empty_l"}, 8'(empty_l), 8'd1);
        check({tag, " empty_m"}, 8'(empty_m), 8'd1);
        check({tag, " ready_l"}, 8'(ready_l), 8'd1);
        check({tag, " ready_m"}, 8'(ready_m), 8'd1);
    endtask

    // Expected sequences: first transmitted bit in bit 7, then leftwards-to-right.
    typedef struct {
        logic [7:0]  data;
        logic [3:0]  len;
        int unsigned l;
        logic [7:0]  exp_lsb;
        logic [7:0]  exp_msb;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        vecs[0] = '{data: 8'hA5, len: 4'd0,  l: 8, exp_lsb: 8'hA5, exp_msb: 8'hA5};
        vecs[1] = '{data: 8'h0B, len: 4'd4,  l: 4, exp_lsb: 8'hD0, exp_msb: 8'hB0};
        vecs[2] = '{data: 8'h1E, len: 4'd9,  l: 8, exp_lsb: 8'h78, exp_msb: 8'h1E};
        vecs[3] = '{data: 8'hF6, len: 4'd3,  l: 3, exp_lsb: 8'h60, exp_msb: 8'hC0};
        vecs[4] = '{data: 8'h35, len: 4'd15, l: 8, exp_lsb: 8'hAC, exp_msb: 8'h35};
        vecs[5] = '{data: 8'h01, len: 4'd1,  l: 1, exp_lsb: 8'h80, exp_msb: 8'h80};
        vecs[6] = '{data: 8'h00, len: 4'd1,  l: 1, exp_lsb: 8'h00, exp_msb: 8'h00};
        vecs[7] = '{data: 8'h01, len: 4'd1,  l: 1, exp_lsb: 8'h80, exp_msb: 8'h80};

        reset     = 1'b0;
        par_valid = 1'b0;
        par_data  = '0;
        par_len   = '0;
        ser_ready = 1'b1;

        // Reset held, then idle after release.
        repeat (2) begin
            @(negedge clk);
            check_idle("in_reset");
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("idle");
        end

        // Table frames, each next word offered on the previous last-bit cycle.
        par_valid = 1'b1;
        par_data  = vecs[0].data;
        par_len   = vecs[0].len;
        for (int v = 0; v < 8; v++) begin
            @(posedge clk);
            for (int i = 0; i < int'(vecs[v].l); i++) begin
                @(negedge clk);
                check($sformatf("v%0d b%0d valid_l", v, i), 8'(valid_l), 8'd1);
                check($sformatf("v%0d b%0d valid_m", v, i), 8'(valid_m), 8'd1);
                check($sformatf("v%0d b%0d ser_l", v, i), 8'(ser_l), 8'(vecs[v].exp_lsb[7-i]));
                check($sformatf("v%0d b%0d ser_m", v, i), 8'(ser_m), 8'(vecs[v].exp_msb[7-i]));
                check($sformatf("v%0d b%0d last_l", v, i), 8'(last_l),
                      8'(i == int'(vecs[v].l) - 1));
                check($sformatf("v%0d b%0d last_m", v, i), 8'(last_m),
                      8'(i == int'(vecs[v].l) - 1));
                check($sformatf("v%0d b%0d ready_l", v, i), 8'(ready_l),
                      8'(i == int'(vecs[v].l) - 1));
                if (i == int'(vecs[v].l) - 1 && v < 7) begin
                    par_valid = 1'b1;
                    par_data  = vecs[v+1].data;
                    par_len   = vecs[v+1].len;
                end else begin
                    par_valid = 1'b0;
                end
                if (i != int'(vecs[v].l) - 1) @(posedge clk);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_idle("after_table");

        // Back-to-back 0xFF, 0x00 with a 3-cycle stall mid-frame.
        par_valid = 1'b1;
        par_data  = 8'hFF;
        par_len   = 4'd0;
        @(posedge clk);
        begin
            int k;
            logic rdy;
            k = 0;
            for (int it = 0; it < 19; it++) begin
                @(negedge clk);
                rdy       = !(it >= 3 && it <= 5);
                ser_ready = rdy;
                if (k == 0) par_data = 8'h00;
                if (k >= 8) par_valid = 1'b0;
                #1;
                check($sformatf("b2b it%0d valid_l", it), 8'(valid_l), 8'd1);
                check($sformatf("b2b it%0d valid_m", it), 8'(valid_m), 8'd1);
                check($sformatf("b2b it%0d ser_l", it), 8'(ser_l), 8'(k < 8));
                check($sformatf("b2b it%0d ser_m", it), 8'(ser_m), 8'(k < 8));
                check($sformatf("b2b it%0d last_l", it), 8'(last_l), 8'(k == 7 || k == 15));
                check($sformatf("b2b it%0d ready_l", it), 8'(ready_l),
                      8'((k == 7 || k == 15) && rdy));
                if (rdy) k++;
                @(posedge clk);
            end
            check("b2b bit count", 8'(k), 8'd16);
        end
        ser_ready = 1'b1;
        @(negedge clk);
        check_idle("after_b2b");

        // Reset asserted after 3 bits of 0xA5.
        par_valid = 1'b1;
        par_data  = 8'hA5;
        par_len   = 4'd0;
        @(posedge clk);
        @(negedge clk);
        par_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid bit3 valid_l", 8'(valid_l), 8'd1);
        check("mid bit3 ser_l", 8'(ser_l), 8'd0);
        check("mid bit3 ser_m", 8'(ser_m), 8'd0);
        #2;
        reset = 1'b0;
        #1;
        check_idle("async_reset");
        par_valid = 1'b1;
        par_data  = 8'h0B;
        par_len   = 4'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset_with_valid");
        par_valid = 1'b0;
        reset     = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("post_reset");
        end

        // A fresh word after the aborted frame starts cleanly.
        par_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        par_valid = 1'b0;
        check("fresh valid_m", 8'(valid_m), 8'd1);
        check("fresh ser_m", 8'(ser_m), 8'd1);
        check("fresh ser_l", 8'(ser_l), 8'd1);
        check("fresh last_m", 8'(last_m), 8'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_idle("fresh_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
